// File: rtl/digit_scan_pkg.sv
// Shared types and elaboration helpers for the 7-segment digit scanner.
package digit_scan_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    // Ceiling log2; clog2(1) is 0, so callers must floor widths at 1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/onehot_n_decoder.sv
// Combinational binary-to-one-hot decoder with active-low outputs and active-low enable.
module onehot_n_decoder #(
    parameter int SEL_W      = 3,
    parameter int NUM_DIGITS = 8
) (
    input  logic [SEL_W-1:0]      i_sel,
    input  logic                  i_en_n,
    output logic [NUM_DIGITS-1:0] o_an_n
);

    always_comb begin
        o_an_n = '1;
        if (!i_en_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (i_sel == SEL_W'(i)) begin
                    o_an_n[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/digit_scan_decoder.sv
// Time-multiplexed anode scanner: BLANK gap then SHOW dwell per digit, with
// per-digit blank mask, active-low global enable and a frame-start pulse.
module digit_scan_decoder
    import digit_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SEL_W        = 3,
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  nEn,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [SEL_W-1:0]      digit_sel,
    output logic                  blanking,
    output logic                  frame_tick
);

    localparam int CNT_W_RAW = clog2(max2(DWELL_CYCLES, BLANK_CYCLES));
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_DIGITS - 1);

    if (SEL_W != clog2(NUM_DIGITS)) begin : g_err_sel_w
        $error("digit_scan_decoder: SEL_W must equal clog2(NUM_DIGITS)");
    end
    if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_err_num_digits
        $error("digit_scan_decoder: NUM_DIGITS must be in 2..16");
    end
    if (DWELL_CYCLES < 1) begin : g_err_dwell
        $error("digit_scan_decoder: DWELL_CYCLES must be >= 1");
    end
    if (BLANK_CYCLES < 1) begin : g_err_blank
        $error("digit_scan_decoder: BLANK_CYCLES must be >= 1");
    end

    scan_state_t           r_state;
    scan_state_t           w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [SEL_W-1:0]      r_digit_sel;
    logic [SEL_W-1:0]      w_sel_nxt;
    logic [NUM_DIGITS-1:0] r_an_n;
    logic [NUM_DIGITS-1:0] w_an_n_nxt;
    logic                  r_blanking;
    logic                  r_frame_tick;
    logic                  w_tick_nxt;
    logic                  w_lit_en_n;

    // Next-state: disable overrides the scan; digit_sel only moves at the end of a dwell.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_digit_sel;
        w_tick_nxt  = 1'b0;
        if (nEn) begin
            w_state_nxt = OFF;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                OFF: begin
                    w_state_nxt = BLANK;
                    w_cnt_nxt   = '0;
                end
                BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state_nxt = SHOW;
                        w_cnt_nxt   = '0;
                        w_tick_nxt  = (r_digit_sel == '0);
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (r_cnt == DWELL_LAST) begin
                        w_state_nxt = BLANK;
                        w_cnt_nxt   = '0;
                        w_sel_nxt   = (r_digit_sel == SEL_LAST) ? '0 : r_digit_sel + 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = BLANK;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Anode decode uses next-state values so an_n lines up with state after the edge.
    assign w_lit_en_n = !((w_state_nxt == SHOW) && !nEn && !blank_mask[w_sel_nxt]);

    onehot_n_decoder #(
        .SEL_W      (SEL_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_anode_dec (
        .i_sel  (w_sel_nxt),
        .i_en_n (w_lit_en_n),
        .o_an_n (w_an_n_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= BLANK;
            r_cnt        <= '0;
            r_digit_sel  <= '0;
            r_an_n       <= '1;
            r_blanking   <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_digit_sel  <= w_sel_nxt;
            r_an_n       <= w_an_n_nxt;
            r_blanking   <= (w_state_nxt != SHOW);
            r_frame_tick <= w_tick_nxt;
        end
    end

    assign an_n       = r_an_n;
    assign digit_sel  = r_digit_sel;
    assign blanking   = r_blanking;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_digit_scan_decoder.sv
// Directed bench for digit_scan_decoder: 8-digit and 6-digit instances, DWELL=4, BLANK=2.
module tb_digit_scan_decoder;

    typedef struct {
        logic       nen;
        logic [7:0] mask;
        logic [7:0] an;
        logic [2:0] sel;
        logic       blk;
        logic       tick;
    } vec_t;

    vec_t tbl8 [0:50];
    vec_t tblm [0:50];
    vec_t tbl6 [0:50];

    logic       clk = 1'b0;
    logic       rst;
    logic       nEn8;
    logic       nEn6;
    logic [7:0] mask8;
    logic [5:0] mask6;
    logic [7:0] an8;
    logic [2:0] sel8;
    logic       blk8;
    logic       tick8;
    logic [5:0] an6;
    logic [2:0] sel6;
    logic       blk6;
    logic       tick6;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    digit_scan_decoder #(
        .NUM_DIGITS(8), .SEL_W(3), .DWELL_CYCLES(4), .BLANK_CYCLES(2)
    ) dut8 (
        .clk(clk), .rst(rst), .nEn(nEn8), .blank_mask(mask8),
        .an_n(an8), .digit_sel(sel8), .blanking(blk8), .frame_tick(tick8)
    );

    digit_scan_decoder #(
        .NUM_DIGITS(6), .SEL_W(3), .DWELL_CYCLES(4), .BLANK_CYCLES(2)
    ) dut6 (
        .clk(clk), .rst(rst), .nEn(nEn6), .blank_mask(mask6),
        .an_n(an6), .digit_sel(sel6), .blanking(blk6), .frame_tick(tick6)
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp8(input string tag, input int idx, input logic [7:0] an, input logic [2:0] sel,
                        input logic blk, input logic tick);
        chk({tag, "_an_n"}, idx, 32'(an8), 32'(an));
        chk({tag, "_sel"}, idx, 32'(sel8), 32'(sel));
        chk({tag, "_blanking"}, idx, 32'(blk8), 32'(blk));
        chk({tag, "_tick"}, idx, 32'(tick8), 32'(tick));
    endtask

    task automatic cmp6(input int idx, input vec_t v);
        chk("d6_an_n", idx, 32'(an6), 32'(v.an[5:0]));
        chk("d6_sel", idx, 32'(sel6), 32'(v.sel));
        chk("d6_blanking", idx, 32'(blk6), 32'(v.blk));
        chk("d6_tick", idx, 32'(tick6), 32'(v.tick));
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        nEn8  = 1'b0;
        nEn6  = 1'b0;
        mask6 = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Entry j is the expected output after j edges since reset release (entry 0 = reset state).
    task automatic run_pattern(input string tag, input int j0, input int j1, input bit masked, input bit with6);
        vec_t v;
        for (int j = j0; j <= j1; j++) begin
            v     = masked ? tblm[j] : tbl8[j];
            mask8 = v.mask;
            nEn8  = v.nen;
            if (j > j0) step();
            cmp8(tag, j, v.an, v.sel, v.blk, v.tick);
            if (with6) cmp6(j, tbl6[j]);
        end
    endtask

    initial begin
        for (int j = 0; j <= 50; j++) begin
            int s;
            int p;
            s = (j / 6) % 8;
            p = j % 6;
            tbl8[j].nen  = 1'b0;
            tbl8[j].mask = 8'h00;
            tbl8[j].an   = (p < 2) ? 8'hFF : ~(8'h01 << s);
            tbl8[j].sel  = 3'(s);
            tbl8[j].blk  = (p < 2);
            tbl8[j].tick = (s == 0 && p == 2);
            tblm[j]      = tbl8[j];
            tblm[j].mask = 8'h04;
            if (s == 2) tblm[j].an = 8'hFF;
            s = (j / 6) % 6;
            tbl6[j].nen  = 1'b0;
            tbl6[j].mask = 8'h00;
            tbl6[j].an   = (p < 2) ? 8'hFF : ~(8'h01 << s);
            tbl6[j].sel  = 3'(s);
            tbl6[j].blk  = (p < 2);
            tbl6[j].tick = (s == 0 && p == 2);
        end
        rst   = 1'b1;
        nEn8  = 1'b0;
        nEn6  = 1'b0;
        mask8 = '0;
        mask6 = '0;

        // Reset release, full 8-digit sweep, and 6-digit wrap in parallel.
        do_reset();
        run_pattern("sweep", 0, 50, 1'b0, 1'b1);

        // Static mask on digit 2 keeps its slot dark without shifting digit 3.
        mask8 = 8'h04;
        do_reset();
        run_pattern("mask", 0, 50, 1'b1, 1'b0);

        // Mask toggled mid-dwell darkens and relights on the next edge.
        mask8 = 8'h00;
        do_reset();
        run_pattern("dynmask", 0, 9, 1'b0, 1'b0);
        mask8 = 8'h02;
        step();
        cmp8("dynmask_dark", 10, 8'hFF, 3'd1, 1'b0, 1'b0);
        mask8 = 8'h00;
        step();
        cmp8("dynmask_lit", 11, 8'hFD, 3'd1, 1'b0, 1'b0);
        step();
        cmp8("dynmask_next", 12, 8'hFF, 3'd2, 1'b1, 1'b0);

        // Disable during digit 3, then resume with a full blank + dwell on digit 3.
        do_reset();
        run_pattern("en", 0, 21, 1'b0, 1'b0);
        nEn8 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            cmp8("en_off", k, 8'hFF, 3'd3, 1'b1, 1'b0);
        end
        nEn8 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            cmp8("en_blank", k, 8'hFF, 3'd3, 1'b1, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            cmp8("en_show", k, 8'hF7, 3'd3, 1'b0, 1'b0);
        end
        step();
        cmp8("en_next", 0, 8'hFF, 3'd4, 1'b1, 1'b0);

        // Reset pulse during digit 5 restarts the scan from digit 0.
        do_reset();
        run_pattern("rstmid", 0, 33, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        cmp8("rstpulse", 0, 8'hFF, 3'd0, 1'b1, 1'b0);
        cmp6(0, tbl6[0]);
        rst = 1'b0;
        run_pattern("rstagain", 0, 12, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
